// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Packs decoded instruction field bundles into 16-bit instruction words and
// queues them for an instruction-memory writer.  Each word leaving the queue
// carries a program address that starts at 0 and advances by one per pop,
// wrapping at 12 bits.
//
// Word formats:
//   ADD/SUB/MUL/AND/OR : {op, src1, src2, dest}
//   JMP                : {4'h6, target}
//   NOP                : 16'h0000
//   op 7..15           : illegal; the bundle is consumed and dropped, and
//                        err_illegal pulses for one cycle afterwards.
//
// Configuration macro:
//   INSTR_ENCODER_NOP_STRIP_EN  when defined, NOP bundles are consumed and
//                               dropped (no word, no address, no error).
//
// Parameters:
//   DEPTH        queue depth in entries (power of two, 2..16)
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   in_valid     input bundle present
//   in_ready     encoder can accept a bundle this cycle
//   in_op        opcode
//   in_src1/2    source register indices
//   in_dest      destination register index
//   in_target    jump target (JMP only)
//   flush        synchronous clear of the queue and the address counter
//   out_valid    queue head holds an encoded word
//   out_ready    downstream accepts the head word
//   out_instr    encoded word at the queue head (0 when empty)
//   out_addr     program address of out_instr
//   err_illegal  one-cycle pulse after an illegal opcode is consumed
//   level        current queue occupancy
// -----------------------------------------------------------------------------
module instr_encoder #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_op,
  input  logic [3:0]               in_src1,
  input  logic [3:0]               in_src2,
  input  logic [3:0]               in_dest,
  input  logic [11:0]              in_target,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_instr,
  output logic [11:0]              out_addr,
  output logic                     err_illegal,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_JMP = 4'd6;

  // Queue storage and bookkeeping
  logic [15:0]   mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [LW-1:0] count_reg,  count_next;
  logic [11:0]   addr_reg,   addr_next;
  logic          err_reg,    err_next;

  logic          full;
  logic          empty;
  logic          accept;
  logic          is_illegal;
  logic          is_nop;
  logic          push;
  logic          pop;
  logic [15:0]   enc_word;

  assign full  = (count_reg == LW'(DEPTH));
  assign empty = (count_reg == '0);

  // Held low during reset so nothing is taken while the queue is being cleared.
  // Full is judged on the registered count, so a pop in a full cycle never
  // opens a slot for a push in that same cycle.
  assign in_ready = !rst && !full && !flush;
  assign accept   = in_valid && in_ready;

  assign is_illegal = (in_op > OP_JMP);
  assign is_nop     = (in_op == OP_NOP);

`ifdef INSTR_ENCODER_NOP_STRIP_EN
  assign push = accept && !is_illegal && !is_nop;
`else
  assign push = accept && !is_illegal;
`endif

  // Flush wins over the output handshake: the head is discarded, not popped.
  assign pop = !empty && out_ready && !flush;

  // Word packing
  always_comb begin
    enc_word = 16'h0000;
    unique case (in_op)
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR:
        enc_word = {in_op, in_src1, in_src2, in_dest};
      OP_JMP:
        enc_word = {OP_JMP, in_target};
      default:
        enc_word = 16'h0000;
    endcase
  end

  // Next-state logic
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    addr_next   = addr_reg;
    err_next    = 1'b0;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
      addr_next   = 12'h000;
    end else begin
      err_next = accept && is_illegal;
      if (push) begin
        wr_ptr_next = wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + AW'(1);
        addr_next   = addr_reg + 12'd1;  // natural 12-bit wrap FFF -> 000
      end
      unique case ({push, pop})
        2'b10:   count_next = count_reg + LW'(1);
        2'b01:   count_next = count_reg - LW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  // Control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      addr_reg   <= 12'h000;
      err_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      addr_reg   <= addr_next;
      err_reg    <= err_next;
    end
  end

  // Storage has no reset: its contents are only visible through the head
  // when count_reg is non-zero, and count_reg is cleared by rst and flush.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= enc_word;
    end
  end

  assign out_valid   = !empty;
  assign out_instr   = empty ? 16'h0000 : mem_reg[rd_ptr_reg];
  assign out_addr    = addr_reg;
  assign err_illegal = err_reg;
  assign level       = count_reg;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter DEPTH, default 4, queue depth in entries, power of two, 2..16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  field bundle present.
REQ-005 in_ready  output  1  encoder can accept a bundle this cycle.
REQ-006 in_op  input  4  opcode: 0 NOP, 1 ADD, 2 SUB, 3 MUL, 4 AND, 5 OR, 6 JMP.
REQ-007 in_src1, in_src2, in_dest  input  4 each  register indices.
REQ-008 in_target  input  12  jump target for JMP.
REQ-009 flush  input  1  synchronous clear of queue and address counter.
REQ-010 out_valid  output  1  queue head holds an encoded word.
REQ-011 out_ready  input  1  downstream (instruction memory writer) accepts the word.
REQ-012 out_instr  output  16  encoded instruction at queue head.
REQ-013 out_addr  output  12  program address for out_instr.
REQ-014 err_illegal  output  1  one-cycle pulse on an illegal opcode being consumed.
REQ-015 level  output  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-016 Input handshake: bundle consumed when in_valid && in_ready on a rising edge.
REQ-017 in_ready SHALL equal !full && !flush, combinationally.
REQ-018 Encoding: ADD..OR -> {in_op, in_src1, in_src2, in_dest}; JMP -> {4'h6, in_target}; NOP -> 16'h0000 (other fields ignored).
REQ-019 in_op 7..15 SHALL be consumed but not enqueued; err_illegal SHALL be 1 in the following cycle only.
REQ-020 Legal consumed bundle SHALL be written to the FIFO tail; out_valid SHALL rise one cycle after consumption when queue was empty (latency 1, no combinational in->out path).
REQ-021 Output handshake: head popped when out_valid && out_ready; out_instr/out_addr SHALL hold stable while out_valid && !out_ready.
REQ-022 out_addr SHALL increment by 1 per pop, wrapping 12'hFFF -> 12'h000.
REQ-023 Simultaneous push and pop SHALL leave level unchanged and preserve order.
REQ-024 Full (level==DEPTH): in_ready=0; a pop in that cycle does not enable a push the same cycle.
REQ-025 Empty: out_valid=0; out_ready ignored; out_instr SHALL read 16'h0000.
REQ-026 flush=1: next cycle level=0, out_valid=0, out_addr=0; concurrent input and output handshakes ignored; err_illegal not raised.
REQ-027 level SHALL never exceed DEPTH nor underflow.

Reset
REQ-028 On rst assertion, immediately: level=0, out_valid=0, out_instr=0, out_addr=0, err_illegal=0, in_ready=0 while rst high.
REQ-029 Reset mid-transfer SHALL discard all queued entries; first word after release goes to address 0.
REQ-030 in_ready SHALL become 1 in the first cycle after rst deasserts.

Configuration
REQ-031 Macro INSTR_ENCODER_NOP_STRIP_EN: when defined, consumed NOP bundles SHALL be dropped (not enqueued, no address consumed, no error); when undefined, NOP SHALL enqueue 16'h0000 per REQ-018.

Verification
REQ-032 ADD src1=2, src2=3, dest=4, out_ready=1 -> next cycle out_instr=16'h1234, out_addr=0; following pop -> out_addr=1.
REQ-033 JMP target=12'hABC -> out_instr=16'h6ABC; in_op=4'h9 -> err_illegal one-cycle pulse, level unchanged.
REQ-034 out_ready=0, push DEPTH+1 bundles -> level=DEPTH, in_ready=0, extra bundle held; then out_ready=1 -> words emitted in push order, addresses 0..DEPTH-1.
REQ-035 Preload out_addr to 12'hFFF via 4095 pops, pop two more -> out_addr 12'hFFF then 12'h000.
REQ-036 Queue holding 3 entries, flush=1 with in_valid=1 -> next cycle level=0, out_valid=0, out_addr=0, input not consumed; rst asserted mid-stream -> outputs zero asynchronously.
REQ-037 NOP bundle: macro undefined -> out_instr=16'h0000 at next address; macro defined -> out_valid stays 0, out_addr unchanged.
